// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_encoder
// Description : Encodes field-level RV32 requests (ADD, SUB, ADDI, LW, SW,
//               BEQ, BNE, JAL, LUI) into 32-bit words and writes them to
//               consecutive IMEM word addresses through one output register.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder #(
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [3:0]        req_kind_i,
   input  logic [4:0]        req_rd_i,
   input  logic [4:0]        req_rs1_i,
   input  logic [4:0]        req_rs2_i,
   input  logic [31:0]       req_imm_i,
   input  logic              req_last_i,
   output logic              wr_valid_o,
   input  logic              wr_ready_i,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [31:0]       wr_data_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] err_addr_o,
   output logic [ADDR_W:0]   count_o
);

   localparam logic [ADDR_W-1:0] c_base = ADDR_W'(BASE_ADDR);
   localparam logic [31:0]       c_nop  = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_LAST = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_wr_valid;
   logic [ADDR_W-1:0]   r_wr_addr;
   logic [31:0]         r_wr_data;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W:0]     r_count;
   logic                r_err;
   logic [ADDR_W-1:0]   r_err_addr;
   logic                r_done;

   logic                w_ready;
   logic                w_accept;
   logic                w_wr_fire;
   logic                w_wrap;
   logic                w_legal;
   logic [31:0]         w_enc;
   logic                w_i_ok;
   logic                w_b_ok;
   logic                w_j_ok;

   // A single output register: a new request may enter whenever the held word leaves this cycle.
   assign w_ready   = (r_state == S_RUN) && (!r_wr_valid || wr_ready_i);
   assign w_accept  = req_valid_i && w_ready;
   assign w_wr_fire = r_wr_valid && wr_ready_i;
   assign w_wrap    = (r_addr == {ADDR_W{1'b1}});

   // Signed range checks: upper bits must be a pure sign extension; branch/jump offsets even.
   assign w_i_ok = (req_imm_i[31:11] == '0) || (req_imm_i[31:11] == '1);
   assign w_b_ok = ((req_imm_i[31:12] == '0) || (req_imm_i[31:12] == '1)) && !req_imm_i[0];
   assign w_j_ok = ((req_imm_i[31:20] == '0) || (req_imm_i[31:20] == '1)) && !req_imm_i[0];

   // Field encoding of the current request; illegal requests collapse to a NOP.
   always_comb begin
      w_enc   = c_nop;
      w_legal = 1'b1;
      case (req_kind_i)
         4'd0: w_enc = {7'b0000000, req_rs2_i, req_rs1_i, 3'b000, req_rd_i, 7'h33};
         4'd1: w_enc = {7'b0100000, req_rs2_i, req_rs1_i, 3'b000, req_rd_i, 7'h33};
         4'd2: begin
            w_legal = w_i_ok;
            w_enc   = {req_imm_i[11:0], req_rs1_i, 3'b000, req_rd_i, 7'h13};
         end
         4'd3: begin
            w_legal = w_i_ok;
            w_enc   = {req_imm_i[11:0], req_rs1_i, 3'b010, req_rd_i, 7'h03};
         end
         4'd4: begin
            w_legal = w_i_ok;
            w_enc   = {req_imm_i[11:5], req_rs2_i, req_rs1_i, 3'b010, req_imm_i[4:0], 7'h23};
         end
         4'd5, 4'd6: begin
            w_legal = w_b_ok;
            w_enc   = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i,
                       (req_kind_i == 4'd6) ? 3'b001 : 3'b000,
                       req_imm_i[4:1], req_imm_i[11], 7'h63};
         end
         4'd7: begin
            w_legal = w_j_ok;
            w_enc   = {req_imm_i[20], req_imm_i[10:1], req_imm_i[11], req_imm_i[19:12],
                       req_rd_i, 7'h6F};
         end
         4'd8: begin
            w_legal = (req_imm_i[11:0] == 12'h000);
            w_enc   = {req_imm_i[31:12], req_rd_i, 7'h37};
         end
         default: w_legal = 1'b0;
      endcase
      if (!w_legal) begin
         w_enc = c_nop;
      end
   end

   // Run FSM next-state: load starts from IDLE only, ends after the last word drains.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start_i) w_state_nxt = S_RUN;
         S_RUN:   if (w_accept && req_last_i) w_state_nxt = S_LAST;
         S_LAST:  if (w_wr_fire) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Output register, address counter, error capture and done pulse.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_valid <= 1'b0;
         r_wr_addr  <= c_base;
         r_wr_data  <= '0;
         r_addr     <= c_base;
         r_count    <= '0;
         r_err      <= 1'b0;
         r_err_addr <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= (r_state == S_LAST) && w_wr_fire;
         if ((r_state == S_IDLE) && start_i) begin
            r_addr     <= c_base;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
         end
         if (w_accept) begin
            r_wr_valid <= 1'b1;
            r_wr_addr  <= r_addr;
            r_wr_data  <= w_enc;
            r_addr     <= r_addr + 1'b1;
            r_count    <= r_count + 1'b1;
            if (!w_legal || w_wrap) begin
               r_err <= 1'b1;
               // A bad request blames its own slot; a pure wrap blames the wrapped-to slot.
               if (!r_err) begin
                  r_err_addr <= w_legal ? (r_addr + 1'b1) : r_addr;
               end
            end
         end else if (w_wr_fire) begin
            r_wr_valid <= 1'b0;
         end
      end
   end

   assign req_ready_o = w_ready;
   assign wr_valid_o  = r_wr_valid;
   assign wr_addr_o   = r_wr_addr;
   assign wr_data_o   = r_wr_data;
   assign done_o      = r_done;
   assign err_o       = r_err;
   assign err_addr_o  = r_err_addr;
   assign count_o     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_encoder
// Description : Directed bench for instr_encoder; a wide instance checked
//               through an address/data scoreboard and a 2-bit-address
//               instance sharing the same stimulus for wrap behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic        req_valid_i = 1'b0;
   logic [3:0]  req_kind_i = '0;
   logic [4:0]  req_rd_i = '0;
   logic [4:0]  req_rs1_i = '0;
   logic [4:0]  req_rs2_i = '0;
   logic [31:0] req_imm_i = '0;
   logic        req_last_i = 1'b0;
   logic        wr_ready_i = 1'b1;

   logic        req_ready_o, wr_valid_o, done_o, err_o;
   logic [9:0]  wr_addr_o, err_addr_o;
   logic [10:0] count_o;
   logic [31:0] wr_data_o;

   logic        req_ready2, wr_valid2, done2, err2;
   logic [1:0]  wr_addr2, err_addr2;
   logic [2:0]  count2;
   logic [31:0] wr_data2;

   int          n_vec = 0;
   int          n_err = 0;
   logic [41:0] sb[$];
   logic [9:0]  exp_addr = '0;
   logic [1:0]  e2_addr = '0;

   instr_encoder #(.ADDR_W(10), .BASE_ADDR(0)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_kind_i(req_kind_i), .req_rd_i(req_rd_i), .req_rs1_i(req_rs1_i),
      .req_rs2_i(req_rs2_i), .req_imm_i(req_imm_i), .req_last_i(req_last_i),
      .wr_valid_o(wr_valid_o), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr_o),
      .wr_data_o(wr_data_o), .done_o(done_o), .err_o(err_o),
      .err_addr_o(err_addr_o), .count_o(count_o)
   );

   instr_encoder #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready2),
      .req_kind_i(req_kind_i), .req_rd_i(req_rd_i), .req_rs1_i(req_rs1_i),
      .req_rs2_i(req_rs2_i), .req_imm_i(req_imm_i), .req_last_i(req_last_i),
      .wr_valid_o(wr_valid2), .wr_ready_i(wr_ready_i), .wr_addr_o(wr_addr2),
      .wr_data_o(wr_data2), .done_o(done2), .err_o(err2),
      .err_addr_o(err_addr2), .count_o(count2)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every IMEM write handshake of the wide instance pops one expectation.
   always @(negedge clk_i) begin
      logic [41:0] e;
      if (rst_ni && wr_valid_o && wr_ready_i) begin
         n_vec++;
         assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL unexpected_write observed=%h@%h expected=none", wr_data_o, wr_addr_o);
         end
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("wr_addr", 32'(wr_addr_o), 32'(e[41:32]));
            check("wr_data", wr_data_o, e[31:0]);
         end
      end
   end

   // The 2-bit instance must walk addresses modulo 4.
   always @(negedge clk_i) begin
      if (rst_ni && wr_valid2 && wr_ready_i) begin
         check("wrap_addr", 32'(wr_addr2), 32'(e2_addr));
         e2_addr = e2_addr + 2'd1;
      end
   end

   task automatic start_prog();
      @(posedge clk_i); #1 start_i = 1'b1;
      @(posedge clk_i); #1 start_i = 1'b0;
      exp_addr = '0;
      e2_addr  = '0;
   endtask

   task automatic send(input logic [3:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm, input logic last,
                       input logic [31:0] exp_data);
      bit ok = 1'b0;
      req_kind_i = kind; req_rd_i = rd; req_rs1_i = rs1; req_rs2_i = rs2;
      req_imm_i = imm; req_last_i = last; req_valid_i = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk_i);
         if (req_ready_o) begin
            ok = 1'b1;
            break;
         end
      end
      check("send_accepted", 32'(ok), 32'd1);
      if (ok) begin
         sb.push_back({exp_addr, exp_data});
         exp_addr = exp_addr + 10'd1;
      end
      @(posedge clk_i); #1;
      req_valid_i = 1'b0;
      req_last_i  = 1'b0;
   endtask

   task automatic wait_done();
      int pulses = 0;
      repeat (10) begin
         @(negedge clk_i);
         if (done_o) pulses++;
      end
      check("done_pulses", 32'(pulses), 32'd1);
      check("idle_ready", 32'(req_ready_o), 32'd0);
      check("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk_i);
      check("rst_wr_valid", 32'(wr_valid_o), 32'd0);
      check("rst_wr_addr", 32'(wr_addr_o), 32'd0);
      check("rst_ready", 32'(req_ready_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      check("rst_count", 32'(count_o), 32'd0);
      @(posedge clk_i); #1 rst_ni = 1'b1;

      // Program 1: every legal kind, last word LUI
      start_prog();
      send(4'd2, 5'd1, 5'd0, 5'd0, 32'd5,          1'b0, 32'h0050_0093);
      send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0,          1'b0, 32'h0020_81B3);
      send(4'd1, 5'd3, 5'd1, 5'd2, 32'd0,          1'b0, 32'h4020_81B3);
      send(4'd3, 5'd5, 5'd2, 5'd0, 32'd8,          1'b0, 32'h0081_2283);
      send(4'd4, 5'd0, 5'd2, 5'd5, 32'd12,         1'b0, 32'h0051_2623);
      send(4'd5, 5'd0, 5'd1, 5'd2, -32'sd8,        1'b0, 32'hFE20_8CE3);
      send(4'd6, 5'd0, 5'd3, 5'd4, 32'd20,         1'b0, 32'h0041_9A63);
      send(4'd7, 5'd1, 5'd0, 5'd0, 32'd16,         1'b0, 32'h0100_00EF);
      send(4'd8, 5'd7, 5'd0, 5'd0, 32'h1234_5000,  1'b1, 32'h1234_53B7);
      wait_done();
      check("p1_count", 32'(count_o), 32'd9);
      check("p1_err", 32'(err_o), 32'd0);

      // Program 2: illegal requests emit NOP, first error address captured
      start_prog();
      check("p2_err_cleared", 32'(err_o), 32'd0);
      send(4'd2, 5'd1, 5'd0, 5'd0, 32'd5,          1'b0, 32'h0050_0093);
      send(4'd2, 5'd1, 5'd0, 5'd0, 32'd3,          1'b0, 32'h0030_0093);
      send(4'd2, 5'd1, 5'd0, 5'd0, 32'd4096,       1'b0, 32'h0000_0013);
      send(4'd12, 5'd1, 5'd0, 5'd0, 32'd0,         1'b0, 32'h0000_0013);
      send(4'd2, 5'd1, 5'd0, 5'd0, -32'sd2048,     1'b0, 32'h8000_0093);
      send(4'd5, 5'd0, 5'd1, 5'd2, 32'd3,          1'b0, 32'h0000_0013);
      send(4'd8, 5'd7, 5'd0, 5'd0, 32'h1234_5001,  1'b1, 32'h0000_0013);
      wait_done();
      check("p2_err", 32'(err_o), 32'd1);
      check("p2_err_addr", 32'(err_addr_o), 32'd2);
      check("p2_count", 32'(count_o), 32'd7);

      // Program 3: write back-pressure holds the output and blocks requests
      start_prog();
      wr_ready_i = 1'b0;
      send(4'd2, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093);
      req_kind_i = 4'd0; req_rd_i = 5'd3; req_rs1_i = 5'd1; req_rs2_i = 5'd2;
      req_imm_i = '0; req_last_i = 1'b1; req_valid_i = 1'b1;
      repeat (3) begin
         @(negedge clk_i);
         check("hold_ready", 32'(req_ready_o), 32'd0);
         check("hold_valid", 32'(wr_valid_o), 32'd1);
         check("hold_data", wr_data_o, 32'h0050_0093);
         check("hold_addr", 32'(wr_addr_o), 32'd0);
      end
      @(posedge clk_i); #1 wr_ready_i = 1'b1;
      send(4'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_81B3);
      wait_done();
      check("p3_count", 32'(count_o), 32'd2);

      // Program 4: five words; the 2-bit instance wraps 3 -> 0
      start_prog();
      for (int k = 1; k <= 5; k++) begin
         send(4'd2, 5'd1, 5'd0, 5'd0, 32'(k), (k == 5), (32'(k) << 20) | 32'h93);
      end
      wait_done();
      check("wrap_err", 32'(err2), 32'd1);
      check("wrap_err_addr", 32'(err_addr2), 32'd0);
      check("wrap_count", 32'(count2), 32'd5);
      check("wide_no_err", 32'(err_o), 32'd0);

      // Program 5: reset in the middle of a load
      start_prog();
      wr_ready_i = 1'b0;
      send(4'd4, 5'd0, 5'd2, 5'd5, 32'd12, 1'b0, 32'h0051_2623);
      req_kind_i = 4'd12; req_valid_i = 1'b1;
      @(negedge clk_i);
      check("mid_count", 32'(count_o), 32'd1);
      check("mid_err", 32'(err_o), 32'd0);
      @(posedge clk_i); #3 rst_ni = 1'b0;
      @(negedge clk_i);
      check("mr_wr_valid", 32'(wr_valid_o), 32'd0);
      check("mr_wr_addr", 32'(wr_addr_o), 32'd0);
      check("mr_wr_data", wr_data_o, 32'd0);
      check("mr_count", 32'(count_o), 32'd0);
      check("mr_err", 32'(err_o), 32'd0);
      check("mr_ready", 32'(req_ready_o), 32'd0);
      check("mr_done", 32'(done_o), 32'd0);
      sb.delete();
      req_valid_i = 1'b0;
      wr_ready_i  = 1'b1;
      @(posedge clk_i); #1 rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);
      check("post_rst_ready", 32'(req_ready_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
